// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back pipeline register.
// Holds the default-width bundle used by consumers that do not override DW/RW.
package wb_pkg;
  localparam int DW_DEF   = 32;
  localparam int RW_DEF   = 5;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [DW_DEF-1:0] wd;
    logic [RW_DEF-1:0] rd;
    logic              regw;
    logic              mem2r;
  } wb_pl_t;
endpackage

// File: rtl/wb_pipe_reg_if.sv
// MEM -> WB bundle handshake: upstream (in_*) and write-back (out_*) sides.
interface wb_pipe_reg_if
  import wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_wd;
  logic [RW-1:0] in_rd;
  logic          in_regw;
  logic          in_mem2r;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_wd;
  logic [RW-1:0] out_rd;
  logic          out_regw;
  logic          out_mem2r;

  modport master (
    output in_valid, in_wd, in_rd, in_regw, in_mem2r, out_ready,
    input  in_ready, out_valid, out_wd, out_rd, out_regw, out_mem2r
  );

  modport slave (
    input  in_valid, in_wd, in_rd, in_regw, in_mem2r, out_ready,
    output in_ready, out_valid, out_wd, out_rd, out_regw, out_mem2r
  );
endinterface

// File: rtl/wb_pipe_slot.sv
// One pipeline slot: valid flag plus payload, with load enable, flush and async reset.
module wb_pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         ld,
  input  logic         d_vld,
  input  logic [W-1:0] d_pl,
  output logic         q_vld,
  output logic [W-1:0] q_pl
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= 1'b0;
      q_pl  <= '0;
    end else begin
      if (flush)   q_vld <= 1'b0;
      else if (ld) q_vld <= d_vld;
      // Bubbles moving in leave the old payload in place; only real data is written.
      if (!flush && ld && d_vld) q_pl <= d_pl;
    end
  end
endmodule

// File: rtl/wb_pipe_reg.sv
// Elastic MEM->WB pipeline register: STAGES slots, backpressure, flush,
// occupancy count and a combinational forwarding lookup for the hazard unit.
module wb_pipe_reg
  import wb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int RW     = RW_DEF,
  parameter int STAGES = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  wb_pipe_reg_if.slave                     bus,
  output logic [$clog2(STAGES+1)-1:0]      occupancy,
  input  logic [RW-1:0]                    q_rs,
  output logic                             q_hit,
  output logic [DW-1:0]                    q_data
);
  localparam int OW = $clog2(STAGES+1);

  typedef struct packed {
    logic [DW-1:0] wd;
    logic [RW-1:0] rd;
    logic          regw;
    logic          mem2r;
  } pl_t;

  logic [STAGES-1:0]       vld;
  logic [STAGES-1:0]       adv;
  pl_t  [STAGES-1:0]       pl_q;
  pl_t                     in_pl;
  logic [OW-1:0]           occ_q;
  logic                    acc, cons;

  assign in_pl = '{wd: bus.in_wd, rd: bus.in_rd, regw: bus.in_regw, mem2r: bus.in_mem2r};

  // A slot may move when every slot from it to the tail is full only if the tail drains.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    adv   = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      all_v  = all_v & vld[i];
      adv[i] = bus.out_ready | !all_v;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    logic d_vld;
    pl_t  d_pl;
    if (i == 0) begin : g_head
      assign d_vld = bus.in_valid;
      assign d_pl  = in_pl;
    end else begin : g_body
      assign d_vld = vld[i-1];
      assign d_pl  = pl_q[i-1];
    end
    wb_pipe_slot #(.W($bits(pl_t))) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .ld    (adv[i]),
      .d_vld (d_vld),
      .d_pl  (d_pl),
      .q_vld (vld[i]),
      .q_pl  (pl_q[i])
    );
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.out_wd    = pl_q[STAGES-1].wd;
  assign bus.out_rd    = pl_q[STAGES-1].rd;
  assign bus.out_mem2r = pl_q[STAGES-1].mem2r;
  // Never let the register file write from a bubble.
  assign bus.out_regw  = pl_q[STAGES-1].regw & vld[STAGES-1];

  assign acc  = bus.in_valid & adv[0];
  assign cons = vld[STAGES-1] & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     occ_q <= '0;
    else if (flush) occ_q <= '0;
    else            occ_q <= occ_q + OW'(acc) - OW'(cons);
  end
  assign occupancy = occ_q;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (vld[i] && pl_q[i].regw && (pl_q[i].rd == q_rs) && (q_rs != RW'(ZERO_REG))) begin
        q_hit  = 1'b1;
        q_data = pl_q[i].wd;
      end
    end
  end
endmodule

// File: tb/tb_wb_pipe_reg.sv
// Scoreboard bench for wb_pipe_reg: a 3-slot and a 2-slot instance side by side.
module tb_wb_pipe_reg;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fl3 = 1'b0, fl2 = 1'b0;
  logic [1:0]  occ3, occ2;
  logic [4:0]  qrs3 = '0, qrs2 = '0;
  logic        qh3, qh2;
  logic [31:0] qd3, qd2;
  int          checks = 0;
  int          errors = 0;
  wb_pl_t      sb3[$];
  wb_pl_t      sb2[$];

  wb_pipe_reg_if #(.DW(32), .RW(5)) b3 ();
  wb_pipe_reg_if #(.DW(32), .RW(5)) b2 ();

  wb_pipe_reg #(.DW(32), .RW(5), .STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(fl3), .bus(b3),
    .occupancy(occ3), .q_rs(qrs3), .q_hit(qh3), .q_data(qd3)
  );
  wb_pipe_reg #(.DW(32), .RW(5), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(fl2), .bus(b2),
    .occupancy(occ2), .q_rs(qrs2), .q_hit(qh2), .q_data(qd2)
  );

  always #5 clk = ~clk;

  // Scoreboards: push on accept, pop and compare on write-back consume.
  always @(posedge clk) if (rst_n) begin
    if (b3.out_valid && b3.out_ready) begin
      wb_pl_t e, g;
      g = '{b3.out_wd, b3.out_rd, b3.out_regw, b3.out_mem2r};
      checks++;
      if (sb3.size() == 0) begin
        errors++; $display("FAIL sb3_extra got %h expected none", g);
      end else begin
        e = sb3.pop_front();
        if (g !== e) begin errors++; $display("FAIL sb3_order got %h expected %h", g, e); end
      end
    end
    if (fl3) sb3.delete();
    else if (b3.in_valid && b3.in_ready) sb3.push_back('{b3.in_wd, b3.in_rd, b3.in_regw, b3.in_mem2r});
  end

  always @(posedge clk) if (rst_n) begin
    if (b2.out_valid && b2.out_ready) begin
      wb_pl_t e, g;
      g = '{b2.out_wd, b2.out_rd, b2.out_regw, b2.out_mem2r};
      checks++;
      if (sb2.size() == 0) begin
        errors++; $display("FAIL sb2_extra got %h expected none", g);
      end else begin
        e = sb2.pop_front();
        if (g !== e) begin errors++; $display("FAIL sb2_order got %h expected %h", g, e); end
      end
    end
    if (fl2) sb2.delete();
    else if (b2.in_valid && b2.in_ready) sb2.push_back('{b2.in_wd, b2.in_rd, b2.in_regw, b2.in_mem2r});
  end

  task automatic put3(input logic v, input logic [31:0] wd, input logic [4:0] rd, input logic rw, input logic m);
    b3.in_valid = v; b3.in_wd = wd; b3.in_rd = rd; b3.in_regw = rw; b3.in_mem2r = m;
  endtask

  task automatic put2(input logic v, input logic [31:0] wd, input logic [4:0] rd, input logic rw, input logic m);
    b2.in_valid = v; b2.in_wd = wd; b2.in_rd = rd; b2.in_regw = rw; b2.in_mem2r = m;
  endtask

  task automatic test_reset;
    b3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      put3(1'b1, 32'hC0 + 32'(i), 5'(i + 1), 1'b1, 1'b1);
    end
    @(negedge clk);
    put3(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (b3.out_valid !== 1'b1 || b3.out_wd !== 32'hC0) begin
      errors++; $display("FAIL prereset_out got v=%b wd=%h expected v=1 wd=000000c0", b3.out_valid, b3.out_wd);
    end
    qrs3 = 5'd1;
    #1;
    checks++;
    if (qh3 !== 1'b1 || qd3 !== 32'hC0) begin
      errors++; $display("FAIL prereset_fwd got hit=%b data=%h expected hit=1 data=000000c0", qh3, qd3);
    end
    #2 rst_n = 1'b0;
    #1;
    sb3.delete(); sb2.delete();
    checks++;
    if ({b3.out_valid, b3.out_regw, b3.out_mem2r, occ3, qh3} !== 6'b0 || b3.out_wd !== '0 || b3.out_rd !== '0 || qd3 !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b rw=%b m=%b occ=%0d hit=%b wd=%h rd=%h qd=%h expected all zero",
               b3.out_valid, b3.out_regw, b3.out_mem2r, occ3, qh3, b3.out_wd, b3.out_rd, qd3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    qrs3 = '0;
    #1;
    checks++;
    if (b3.in_ready !== 1'b1 || occ3 !== 2'd0 || b2.in_ready !== 1'b1 || occ2 !== 2'd0) begin
      errors++; $display("FAIL post_reset got rdy3=%b occ3=%0d rdy2=%b occ2=%0d expected 1 0 1 0", b3.in_ready, occ3, b2.in_ready, occ2);
    end
  endtask

  task automatic test_streaming;
    logic exp_v;
    logic [31:0] exp_wd;
    b3.out_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_v  = (k >= 3 && k <= 5);
      exp_wd = 32'(17 * (k - 2));
      checks++;
      if (b3.out_valid !== exp_v || (exp_v && b3.out_wd !== exp_wd)) begin
        errors++; $display("FAIL stream_k%0d got v=%b wd=%h expected v=%b wd=%h", k, b3.out_valid, b3.out_wd, exp_v, exp_wd);
      end
      if (k < 3) put3(1'b1, 32'(17 * (k + 1)), 5'(k + 10), 1'b1, k[0]);
      else       put3(1'b0, '0, '0, 1'b0, 1'b0);
    end
    checks++;
    if (sb3.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left expected 0", sb3.size()); end
  endtask

  task automatic test_backpressure;
    b2.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b expected 1", b2.in_ready); end
    put2(1'b1, 32'hB0, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    put2(1'b1, 32'hB1, 5'd2, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (occ2 !== 2'd2 || b2.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got occ=%0d rdy=%b expected occ=2 rdy=0", occ2, b2.in_ready);
    end
    put2(1'b1, 32'hB2, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (occ2 !== 2'd2 || b2.in_ready !== 1'b0 || b2.out_wd !== 32'hB0) begin
      errors++; $display("FAIL bp_hold got occ=%0d rdy=%b wd=%h expected occ=2 rdy=0 wd=000000b0", occ2, b2.in_ready, b2.out_wd);
    end
    b2.out_ready = 1'b1;
    #1;
    checks++;
    if (b2.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got rdy=%b expected 1", b2.in_ready); end
    @(negedge clk);
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (occ2 !== 2'd2 || b2.out_wd !== 32'hB1) begin
      errors++; $display("FAIL bp_swap got occ=%0d wd=%h expected occ=2 wd=000000b1", occ2, b2.out_wd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (occ2 !== 2'd0 || b2.out_valid !== 1'b0 || sb2.size() != 0) begin
      errors++; $display("FAIL bp_drain got occ=%0d v=%b left=%0d expected 0 0 0", occ2, b2.out_valid, sb2.size());
    end
  endtask

  task automatic test_flush;
    b2.out_ready = 1'b0;
    @(negedge clk);
    put2(1'b1, 32'hF0, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    put2(1'b1, 32'hF1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (occ2 !== 2'd2) begin errors++; $display("FAIL fl_fill got occ=%0d expected 2", occ2); end
    put2(1'b1, 32'hF2, 5'd6, 1'b1, 1'b0);
    b2.out_ready = 1'b1;
    fl2 = 1'b1;
    @(negedge clk);
    fl2 = 1'b0;
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (occ2 !== 2'd0 || b2.out_valid !== 1'b0 || b2.in_ready !== 1'b1) begin
      errors++; $display("FAIL fl_clear got occ=%0d v=%b rdy=%b expected 0 0 1", occ2, b2.out_valid, b2.in_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (occ2 !== 2'd0 || b2.out_valid !== 1'b0) begin
        errors++; $display("FAIL fl_absent%0d got occ=%0d v=%b expected 0 0", k, occ2, b2.out_valid);
      end
    end
  endtask

  task automatic test_forwarding;
    b2.out_ready = 1'b0;
    @(negedge clk);
    put2(1'b1, 32'hA, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    put2(1'b1, 32'hB, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    qrs2 = 5'd5;
    #1;
    checks++;
    if (qh2 !== 1'b1 || qd2 !== 32'hB) begin errors++; $display("FAIL fwd_young got hit=%b data=%h expected 1 0000000b", qh2, qd2); end
    qrs2 = 5'd0;
    #1;
    checks++;
    if (qh2 !== 1'b0 || qd2 !== 32'h0) begin errors++; $display("FAIL fwd_zero got hit=%b data=%h expected 0 0", qh2, qd2); end
    qrs2 = 5'd7;
    #1;
    checks++;
    if (qh2 !== 1'b0 || qd2 !== 32'h0) begin errors++; $display("FAIL fwd_miss got hit=%b data=%h expected 0 0", qh2, qd2); end
    fl2 = 1'b1;
    @(negedge clk);
    fl2 = 1'b0;
    put2(1'b1, 32'hC, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    qrs2 = 5'd9;
    #1;
    checks++;
    if (qh2 !== 1'b0 || qd2 !== 32'h0 || occ2 !== 2'd1) begin
      errors++; $display("FAIL fwd_noregw got hit=%b data=%h occ=%0d expected 0 0 1", qh2, qd2, occ2);
    end
    b2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    qrs2 = '0;
  endtask

  task automatic test_bubble;
    b2.out_ready = 1'b1;
    @(negedge clk);
    put2(1'b1, 32'hE, 5'd3, 1'b1, 1'b1);
    @(negedge clk);
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_regw !== 1'b1) begin
      errors++; $display("FAIL bub_live got v=%b rw=%b expected 1 1", b2.out_valid, b2.out_regw);
    end
    @(negedge clk);
    checks++;
    if (b2.out_valid !== 1'b0 || b2.out_regw !== 1'b0) begin
      errors++; $display("FAIL bub_guard got v=%b rw=%b expected 0 0", b2.out_valid, b2.out_regw);
    end
  endtask

  initial begin
    put3(1'b0, '0, '0, 1'b0, 1'b0);
    put2(1'b0, '0, '0, 1'b0, 1'b0);
    b3.out_ready = 1'b0;
    b2.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_forwarding();
    test_bubble();
    checks++;
    if (sb2.size() != 0 || sb3.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d/%0d expected 0/0", sb3.size(), sb2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
